// File: rtl/program_loader.sv
// program_loader: streams programmer bytes into the 16x8 RAM through the shared MAR/RAM bus.
// Latency: byte accepted at edge N -> MAR_LD in cycle N+1, RAM_WE in N+2, READY again N+3 (N+4 with verify).
// Backpressure: READY only in WAIT_BYTE; the producer holds PRGM/PRGM_IN until READY && PRGM on an edge.
//
// Optional feature macro: LOADER_VERIFY_EN adds a VERIFY read-back cycle per byte, RAM_RD and sticky ERR.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   GO, START_ADDR, LEN session start command (sampled in IDLE only), start address, byte count
//   PRGM_IN, PRGM       program byte and its valid
//   RAM_Q               combinational RAM read data at the current MAR address
//   READY, BUSY, DONE   handshake ready, session active, one-cycle end-of-session pulse
//   ERR                 sticky verify mismatch (0 without LOADER_VERIFY_EN)
//   BUS_OUT, BUS_EN     shared bus drive value and ownership
//   MAR_LD, RAM_WE      MAR load strobe, RAM write strobe
//   RAM_RD              verify read strobe
//   COUNT               bytes written this session
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              GO,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   LEN,
    input  logic [DATA_W-1:0] PRGM_IN,
    input  logic              PRGM,
    input  logic [DATA_W-1:0] RAM_Q,
    output logic              READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] BUS_OUT,
    output logic              BUS_EN,
    output logic              MAR_LD,
    output logic              RAM_WE,
    output logic              RAM_RD,
    output logic [ADDR_W:0]   COUNT
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BYTE, S_ADDR, S_DATA, S_VERIFY
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BYTE, S_ADDR, S_DATA
    } state_t;
`endif

    localparam logic [ADDR_W:0]   LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     len_clamped;
    logic [ADDR_W:0]     count_inc;
    logic                advance;

`ifdef LOADER_VERIFY_EN
    logic                err_q, err_d;
`else
    // RAM_Q is only consumed by the verify logic.
    logic                unused_ram_q;
    assign unused_ram_q = ^RAM_Q;
`endif

    assign len_clamped = (LEN > LEN_MAX) ? LEN_MAX : LEN;
    assign count_inc   = count_q + COUNT_ONE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
`ifdef LOADER_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
`ifdef LOADER_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        advance = 1'b0;
`ifdef LOADER_VERIFY_EN
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (GO) begin
                    addr_d  = START_ADDR;
                    len_d   = len_clamped;
                    count_d = '0;
`ifdef LOADER_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    // An empty session ends immediately without touching the bus.
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_BYTE;
                    end
                end
            end
            S_WAIT_BYTE: begin
                if (PRGM) begin
                    byte_d  = PRGM_IN;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
            end
            S_DATA: begin
`ifdef LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                advance = 1'b1;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                // A mismatch is recorded but the session carries on.
                if (RAM_Q != byte_q) begin
                    err_d = 1'b1;
                end
                advance = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Per-byte bookkeeping when the write (and optional verify) has finished.
        if (advance) begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_inc;
            if (count_inc == len_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_WAIT_BYTE;
            end
        end
    end

    // Strobes are decodes of the state register; RESET masks them so a write
    // coinciding with reset never reaches the RAM.
    assign READY   = !RESET && (state_q == S_WAIT_BYTE);
    assign BUSY    = !RESET && (state_q != S_IDLE);
    assign BUS_EN  = !RESET && ((state_q == S_ADDR) || (state_q == S_DATA));
    assign MAR_LD  = !RESET && (state_q == S_ADDR);
    assign RAM_WE  = !RESET && (state_q == S_DATA);
    assign BUS_OUT = RESET                 ? '0 :
                     (state_q == S_ADDR)   ? {{(DATA_W-ADDR_W){1'b0}}, addr_q} :
                     (state_q == S_DATA)   ? byte_q : '0;
    assign DONE    = done_q;
    assign COUNT   = count_q;

`ifdef LOADER_VERIFY_EN
    assign RAM_RD  = !RESET && (state_q == S_VERIFY);
    assign ERR     = err_q;
`else
    assign RAM_RD  = 1'b0;
    assign ERR     = 1'b0;
`endif

endmodule
